// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
package sipo_pkg;

  localparam int SIPO_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_e;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit shift register; load_first clears the word and places the first bit.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load_first,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] shift_val;

  // MSB-first shifts toward the MSB so the first bit ends in data[WIDTH-1].
  if (MSB_FIRST != 0) begin : g_msb
    assign load_val  = {{(WIDTH-1){1'b0}}, bit_in};
    assign shift_val = {data[WIDTH-2:0], bit_in};
  end else begin : g_lsb
    assign load_val  = {bit_in, {(WIDTH-1){1'b0}}};
    assign shift_val = {bit_in, data[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load_first) begin
      data <= load_val;
    end else if (shift_en) begin
      data <= shift_val;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with framing, holding register and handshake.
// state | meaning
// IDLE  | waiting for a frame_start-qualified bit
// SHIFT | assembling words; wraps back-to-back without a new frame_start
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  sipo_state_e      state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sr_data;
  logic             done_q;
  logic             accept_first;
  logic             accept_shift;
  logic             complete;

  always_comb begin
    accept_first = bit_valid && frame_start;
    accept_shift = bit_valid && !frame_start && (state == SHIFT);
    complete     = accept_shift && (count == CNT_LAST);
  end

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (accept_shift),
    .load_first (accept_first),
    .bit_in     (bit_in),
    .data       (sr_data)
  );

  // done_q delays the transfer one edge so sr_data already holds the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      done_q     <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      done_q    <= complete;

      if (accept_first) begin
        state     <= SHIFT;
        count     <= CNT_ONE;
        frame_err <= (state == SHIFT) && (count != '0);
      end else if (accept_shift) begin
        count <= complete ? '0 : count + CNT_ONE;
      end

      if (done_q) begin
        if (word_valid && !word_ready) begin
          overrun <= 1'b1;
        end else begin
          word_data  <= sr_data;
          word_valid <= 1'b1;
        end
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench: one MSB-first and one LSB-first deserializer share the same stimulus.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       frame_start;
  logic       word_ready;
  logic [7:0] wd_m, wd_l;
  logic       wv_m, wv_l, ov_m, ov_l, fe_m, fe_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .word_data(wd_m), .word_valid(wv_m),
    .word_ready(word_ready), .overrun(ov_m), .frame_err(fe_m)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .word_data(wd_l), .word_valid(wv_l),
    .word_ready(word_ready), .overrun(ov_l), .frame_err(fe_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic bv, input logic fs, input logic rdy);
    bit_in      = b;
    bit_valid   = bv;
    frame_start = fs;
    word_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic send_word(input logic [7:0] w, input logic fs, input logic rdy);
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1, fs && (i == 7), rdy);
  endtask

  initial begin
    rst = 1'b1;
    bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; word_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    chk("rst_valid", wv_m, 0);
    chk("rst_data", wd_m, 8'h00);
    chk("rst_overrun", ov_m, 0);
    chk("rst_frame_err", fe_m, 0);
    chk("rst_valid_lsb", wv_l, 0);

    // A5 with consumer always ready: valid one edge after the last bit, for one cycle
    send_word(8'hA5, 1'b1, 1'b1);
    chk("a5_latency", wv_m, 0);
    idle(1'b1);
    chk("a5_valid", wv_m, 1);
    chk("a5_data", wd_m, 8'hA5);
    chk("a5_data_lsb", wd_l, 8'hA5);
    idle(1'b1);
    chk("a5_one_cycle", wv_m, 0);

    // C3 with a bit_valid gap mid-word; frame_start at a word boundary is not an error
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("c3_no_fe", fe_m, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("c3_valid", wv_m, 1);
    chk("c3_data", wd_m, 8'hC3);
    chk("c3_data_lsb", wd_l, 8'hC3);
    idle(1'b1);
    chk("c3_taken", wv_m, 0);

    send_word(8'h80, 1'b1, 1'b0);
    idle(1'b0);
    chk("x80_valid", wv_m, 1);
    chk("x80_data", wd_m, 8'h80);
    chk("x80_data_lsb", wd_l, 8'h01);
    idle(1'b1);
    chk("x80_taken", wv_m, 0);

    // 12 then 34 back-to-back, never ready: 34 is dropped with one overrun pulse
    send_word(8'h12, 1'b1, 1'b0);
    send_word(8'h34, 1'b0, 1'b0);
    chk("ovr_not_yet", ov_m, 0);
    chk("ovr_held_pre", wd_m, 8'h12);
    idle(1'b0);
    chk("ovr_pulse", ov_m, 1);
    chk("ovr_pulse_lsb", ov_l, 1);
    chk("ovr_held", wd_m, 8'h12);
    chk("ovr_still_valid", wv_m, 1);
    idle(1'b0);
    chk("ovr_single", ov_m, 0);
    idle(1'b1);
    chk("ovr_taken", wv_m, 0);
    idle(1'b1);
    chk("ovr_no_34", wv_m, 0);

    // frame_start after 3 bits aborts the partial word
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("fe_quiet", fe_m, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("fe_pulse", fe_m, 1);
    chk("fe_pulse_lsb", fe_l, 1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("fe_single", fe_m, 0);
    idle(1'b1);
    chk("fe_valid", wv_m, 1);
    chk("fe_data", wd_m, 8'hFF);
    idle(1'b1);

    // reset mid-word; bits without frame_start afterwards are ignored
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst2_valid", wv_m, 0);
    chk("rst2_data", wd_m, 8'h00);
    send_word(8'hF0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("rst2_ignored", wv_m, 0);
    chk("rst2_ignored_lsb", wv_l, 0);
    send_word(8'h96, 1'b1, 1'b0);
    idle(1'b0);
    chk("rst2_word_valid", wv_m, 1);
    chk("rst2_word_data", wd_m, 8'h96);
    chk("rst2_word_lsb", wd_l, 8'h69);
    idle(1'b1);

    // AA held, ready on the edge where 55 transfers: seamless handoff
    send_word(8'hAA, 1'b1, 1'b0);
    send_word(8'h55, 1'b0, 1'b0);
    chk("hand_held", wd_m, 8'hAA);
    chk("hand_held_valid", wv_m, 1);
    idle(1'b1);
    chk("hand_valid", wv_m, 1);
    chk("hand_data", wd_m, 8'h55);
    chk("hand_data_lsb", wd_l, 8'hAA);
    chk("hand_no_ovr", ov_m, 0);
    idle(1'b1);
    chk("hand_taken", wv_m, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
